// File: rtl/uart_frame_serializer.sv
// uart_frame_serializer: one-word UART TX framer (start, data, optional parity, stop) stepped by baud tick; parity compiled in by UART_SER_PARITY_EN
module uart_frame_serializer #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int MSB_FIRST = 0,
  parameter int PAR_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [2:0] {
    IDLE,
    PEND,
    START,
    DATA,
`ifdef UART_SER_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
`ifdef UART_SER_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic par;
`else
  localparam state_t AFTER_DATA = STOP;
  logic unused_par_odd;
  assign unused_par_odd = PAR_ODD != 0;
`endif
  state_t state, state_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [CW-1:0] cnt;
  logic stop_cnt, last_bit, last_stop, tx_n;
  assign last_bit  = cnt == CW'(DATA_W - 1);
  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  assign s_ready   = state == IDLE;
  assign busy      = state != IDLE;
  always_comb begin
    state_n = state;
    shift_n = shift;
    done    = 1'b0;
    case (state)
      IDLE:   if (s_valid) begin
        state_n = PEND;
        shift_n = s_data;
      end
      PEND:   state_n = tick ? START : PEND;
      START:  state_n = tick ? DATA : START;
      DATA:   if (tick) begin
        state_n = last_bit ? AFTER_DATA : DATA;
        shift_n = MSB_FIRST != 0 ? shift << 1 : shift >> 1;
      end
`ifdef UART_SER_PARITY_EN
      PARITY: state_n = tick ? STOP : PARITY;
`endif
      STOP:   if (tick && last_stop) begin
        state_n = IDLE;
        done    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    tx_n = state_n == START ? 1'b0 :
           state_n == DATA  ? (MSB_FIRST != 0 ? shift_n[DATA_W-1] : shift_n[0]) :
`ifdef UART_SER_PARITY_EN
           state_n == PARITY ? par :
`endif
           1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      cnt      <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
`ifdef UART_SER_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      tx       <= tx_n;
      cnt      <= state != DATA ? '0 : (tick && !last_bit) ? cnt + 1'b1 : cnt;
      stop_cnt <= state == STOP && (stop_cnt ^ tick);
`ifdef UART_SER_PARITY_EN
      if (state == IDLE && s_valid) par <= (^s_data) ^ (PAR_ODD != 0);
`endif
    end
  end
endmodule
